// File: rtl/inst_reload_ctrl.sv
// ---------------------------------------------------------------------------
// inst_reload_ctrl
//
// Loads batches of 16-bit instruction words from a host stream into the
// shared 8-bit instruction/data memory of the serial CPU. Each word becomes
// two byte writes: the low byte goes to an even address and the high byte to
// the next odd address. Batches start at byte address DEFAULT_PC_ADDR*2.
// After a batch is written, the block pulses `start`. It reloads when the CPU
// reports instruction exhaustion and stops for good when the CPU halts.
//
// Optional feature (compile-time macro RELOAD_APPEND_HALT_EN):
//   When defined, a HALT instruction word is appended after the host's last
//   word, provided the batch still has room for it.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   nxt[1:0]   - CPU status: [0] program halted, [1] instructions exhausted
//   inst_valid - host word valid
//   inst_data  - host instruction word
//   inst_last  - final word of the batch (qualified by inst_valid)
//   inst_ready - word accepted when inst_valid && inst_ready
//   mem_own    - 1 = memory address/data/we come from this block
//   m_addr     - memory byte address
//   m_we       - memory write enable
//   m_dataout  - memory write byte
//   start      - one-cycle CPU start pulse
//   cpu_halt   - sticky halt flag
//   batch_cnt  - number of batches launched (wraps at 255 -> 0)
//   err        - sticky batch-overflow flag
// ---------------------------------------------------------------------------
module inst_reload_ctrl #(
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int DEFAULT_PC_ADDR   = 250,
    parameter int MAX_WORDS         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   nxt,
    input  logic                         inst_valid,
    input  logic [15:0]                  inst_data,
    input  logic                         inst_last,
    output logic                         inst_ready,
    output logic                         mem_own,
    output logic [MEMORY_ADDR_WIDTH-1:0] m_addr,
    output logic                         m_we,
    output logic [7:0]                   m_dataout,
    output logic                         start,
    output logic                         cpu_halt,
    output logic [7:0]                   batch_cnt,
    output logic                         err
);

    localparam int KW = $clog2(MAX_WORDS + 1);
    localparam logic [MEMORY_ADDR_WIDTH-1:0] BASE_ADDR = MEMORY_ADDR_WIDTH'(DEFAULT_PC_ADDR * 2);
    localparam logic [KW-1:0] K_MAX = KW'(MAX_WORDS);

`ifdef RELOAD_APPEND_HALT_EN
    // HALT opcode in the top five bits, matching the CPU's instruction encoding.
    localparam logic [4:0]  HALT_OPCODE = 5'b11111;
    localparam logic [15:0] HALT_WORD   = {HALT_OPCODE, 11'b0};
`endif

    typedef enum logic [2:0] {
        LOAD_LO,
        LOAD_HI,
        START,
        RUN,
        HALTED
`ifdef RELOAD_APPEND_HALT_EN
        ,
        APPEND_LO,
        APPEND_HI
`endif
    } state_t;

    state_t                         state, state_n;
    logic [KW-1:0]                  k, k_n;
    logic [7:0]                     hi_byte, hi_byte_n;
    logic                           last_q, last_n;
    logic [1:0]                     nxt_r, nxt_q;
    logic                           inst_ready_n, mem_own_n, m_we_n, start_n;
    logic                           cpu_halt_n, err_n;
    logic [MEMORY_ADDR_WIDTH-1:0]   m_addr_n;
    logic [7:0]                     m_dataout_n, batch_cnt_n;
    logic [MEMORY_ADDR_WIDTH-1:0]   lo_addr, hi_addr;
    logic                           accept;
    logic [1:0]                     nxt_rise;

    // Byte addresses of the current word slot; arithmetic wraps at the
    // address width. The base is always even, so hi = lo + 1 stays in-word.
    assign lo_addr  = BASE_ADDR + MEMORY_ADDR_WIDTH'({k, 1'b0});
    assign hi_addr  = lo_addr + MEMORY_ADDR_WIDTH'(1);
    assign accept   = inst_valid && inst_ready;
    // Edge detect on a registered copy so that levels left high from a
    // previous run never retrigger a reload or halt.
    assign nxt_rise = nxt_r & ~nxt_q;

    // State register plus every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_LO;
            k          <= '0;
            hi_byte    <= '0;
            last_q     <= 1'b0;
            nxt_r      <= 2'b00;
            nxt_q      <= 2'b00;
            inst_ready <= 1'b0;
            mem_own    <= 1'b0;
            m_addr     <= '0;
            m_we       <= 1'b0;
            m_dataout  <= '0;
            start      <= 1'b0;
            cpu_halt   <= 1'b0;
            batch_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            hi_byte    <= hi_byte_n;
            last_q     <= last_n;
            nxt_r      <= nxt;
            nxt_q      <= nxt_r;
            inst_ready <= inst_ready_n;
            mem_own    <= mem_own_n;
            m_addr     <= m_addr_n;
            m_we       <= m_we_n;
            m_dataout  <= m_dataout_n;
            start      <= start_n;
            cpu_halt   <= cpu_halt_n;
            batch_cnt  <= batch_cnt_n;
            err        <= err_n;
        end
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered, so a write decided in one state is visible on the port
    // during the following cycle.
    always_comb begin
        state_n      = state;
        k_n          = k;
        hi_byte_n    = hi_byte;
        last_n       = last_q;
        m_addr_n     = m_addr;
        m_dataout_n  = m_dataout;
        m_we_n       = 1'b0;
        cpu_halt_n   = cpu_halt;
        err_n        = err;
        batch_cnt_n  = batch_cnt;

        case (state)
            LOAD_LO: begin
                if (accept) begin
                    hi_byte_n = inst_data[15:8];
                    last_n    = inst_last;
                    state_n   = LOAD_HI;
                    // A full batch swallows further words without writing.
                    if (k == K_MAX) begin
                        err_n = 1'b1;
                    end else begin
                        m_addr_n    = lo_addr;
                        m_dataout_n = inst_data[7:0];
                        m_we_n      = 1'b1;
                    end
                end
            end

            LOAD_HI: begin
                // k only advances on real writes, so k == K_MAX here means
                // the low half of this word was suppressed as well.
                if (k != K_MAX) begin
                    m_addr_n    = hi_addr;
                    m_dataout_n = hi_byte;
                    m_we_n      = 1'b1;
                    k_n         = k + KW'(1);
                end
                if (last_q) begin
`ifdef RELOAD_APPEND_HALT_EN
                    if (k_n == K_MAX) begin
                        err_n   = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = APPEND_LO;
                    end
`else
                    state_n = START;
`endif
                end else begin
                    state_n = LOAD_LO;
                end
            end

`ifdef RELOAD_APPEND_HALT_EN
            APPEND_LO: begin
                m_addr_n    = lo_addr;
                m_dataout_n = HALT_WORD[7:0];
                m_we_n      = 1'b1;
                state_n     = APPEND_HI;
            end

            APPEND_HI: begin
                m_addr_n    = hi_addr;
                m_dataout_n = HALT_WORD[15:8];
                m_we_n      = 1'b1;
                state_n     = START;
            end
`endif

            START: begin
                k_n     = '0;
                state_n = RUN;
            end

            RUN: begin
                // Halt takes precedence when both bits rise together.
                if (nxt_rise[0]) begin
                    cpu_halt_n = 1'b1;
                    state_n    = HALTED;
                end else if (nxt_rise[1]) begin
                    state_n = LOAD_LO;
                end
            end

            HALTED: begin
                state_n = HALTED;
            end

            default: begin
                state_n = LOAD_LO;
            end
        endcase

        start_n = (state_n == START);
        if (start_n) begin
            batch_cnt_n = batch_cnt + 8'd1;
        end
        inst_ready_n = (state_n == LOAD_LO);
        // The final byte of a batch is on the port during the START cycle;
        // ownership is held for any cycle that carries a write so that byte
        // actually reaches memory.
        mem_own_n = (state_n == LOAD_LO) || (state_n == LOAD_HI) || m_we_n;
`ifdef RELOAD_APPEND_HALT_EN
        if ((state_n == APPEND_LO) || (state_n == APPEND_HI)) begin
            mem_own_n = 1'b1;
        end
`endif
    end

endmodule
